// File: rtl/mem_line_pkg.sv
// Shared types and constants for the line-granular memory front-end.
package mem_line_pkg;

    localparam int unsigned LINE_W         = 256;
    localparam int unsigned WORD_W         = 32;
    localparam int unsigned BE_W           = 4;
    localparam int unsigned OFFSET_BITS    = 5;
    localparam int unsigned WORDS_PER_LINE = 8;
    localparam int unsigned WIDX_W         = 3;

    typedef logic [LINE_W-1:0] line_t;
    typedef logic [WORD_W-1:0] word_t;
    typedef logic [WIDX_W-1:0] widx_t;
    typedef logic [BE_W-1:0]   be_t;

    typedef enum logic [2:0] {
        IDLE,
        RD_A,
        RD_B,
        WR_FETCH,
        WR_STORE,
        RESP_A,
        RESP_B
    } state_e;

    // Transaction payload captured at grant time.
    typedef struct packed {
        widx_t widx;
        word_t data;
        be_t   be;
    } xfer_t;

    // Select one 32-bit word out of a line.
    function automatic word_t get_word(input line_t line, input widx_t idx);
        return line[{idx, 5'b00000} +: WORD_W];
    endfunction

endpackage

// File: rtl/line_merge.sv
// Byte-enable merge of a 32-bit store word into a full memory line.
module line_merge
    import mem_line_pkg::*;
(
    input  logic [LINE_W-1:0] line,
    input  logic [WIDX_W-1:0] word_idx,
    input  logic [WORD_W-1:0] wdata,
    input  logic [BE_W-1:0]   mbe,
    output logic [LINE_W-1:0] merged_c
);

    // Overwrite only the enabled bytes of the addressed word.
    always_comb begin
        merged_c = line;
        for (int unsigned b = 0; b < BE_W; b++) begin
            if (mbe[b]) begin
                merged_c[{word_idx, 2'(b), 3'b000} +: 8] = wdata[8*b +: 8];
            end
        end
    end

endmodule

// File: rtl/mem_line_arbiter.sv
// Two-port (fetch / load-store) front-end onto a single line-wide memory.
module mem_line_arbiter
    import mem_line_pkg::*;
#(
    parameter int unsigned LINE_BITS = 256,
    parameter int unsigned ADDR_BITS = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,

    input  logic                 read_a,
    input  logic [ADDR_BITS-1:0] address_a,
    output logic                 resp_a,
    output logic [31:0]          rdata_a,

    input  logic                 read_b,
    input  logic                 write,
    input  logic [ADDR_BITS-1:0] address_b,
    input  logic [31:0]          wdata,
    input  logic [3:0]           mbe,
    output logic                 resp_b,
    output logic [31:0]          rdata_b,

    output logic                 pmem_read,
    output logic                 pmem_write,
    output logic [ADDR_BITS-1:0] pmem_address,
    output logic [LINE_BITS-1:0] pmem_wdata,
    input  logic [LINE_BITS-1:0] pmem_rdata,
    input  logic                 pmem_resp
);

    state_e state_q, state_d;
    logic   last_b_q, last_b_d;
    xfer_t  xfer_q, xfer_d;

    logic                 resp_a_d, resp_b_d;
    word_t                rdata_a_d, rdata_b_d;
    logic                 pmem_read_d, pmem_write_d;
    logic [ADDR_BITS-1:0] pmem_address_d;
    line_t                pmem_wdata_d;

    logic  req_b_c;
    logic  grant_a_c;
    logic  grant_b_c;
    line_t merged_c;
    logic  unused_addr_bits;

    // Byte offset within a word carries no meaning on these ports.
    assign unused_addr_bits = ^{address_a[1:0], address_b[1:0]};

    // Round-robin: on conflict B wins unless it was granted last.
    assign req_b_c   = read_b | write;
    assign grant_b_c = req_b_c & (~read_a | ~last_b_q);
    assign grant_a_c = read_a & (~req_b_c | last_b_q);

    // Store merge operates directly on the fetched line.
    line_merge u_line_merge (
        .line     (pmem_rdata),
        .word_idx (xfer_q.widx),
        .wdata    (xfer_q.data),
        .mbe      (xfer_q.be),
        .merged_c (merged_c)
    );

    // Next-state, capture and registered-output logic.
    always_comb begin
        state_d        = state_q;
        last_b_d       = last_b_q;
        xfer_d         = xfer_q;
        pmem_address_d = pmem_address;
        pmem_wdata_d   = pmem_wdata;
        rdata_a_d      = '0;
        rdata_b_d      = '0;

        unique case (state_q)
            IDLE: begin
                if (grant_b_c) begin
                    last_b_d       = 1'b1;
                    xfer_d         = '{widx: address_b[OFFSET_BITS-1:2], data: wdata, be: mbe};
                    pmem_address_d = {address_b[ADDR_BITS-1:OFFSET_BITS], OFFSET_BITS'(0)};
                    if (write) begin
                        state_d = (mbe == 4'b0000) ? RESP_B : WR_FETCH;
                    end else begin
                        state_d = RD_B;
                    end
                end else if (grant_a_c) begin
                    last_b_d       = 1'b0;
                    xfer_d         = '{widx: address_a[OFFSET_BITS-1:2], data: '0, be: '0};
                    pmem_address_d = {address_a[ADDR_BITS-1:OFFSET_BITS], OFFSET_BITS'(0)};
                    state_d        = RD_A;
                end
            end
            RD_A: begin
                if (pmem_resp) begin
                    rdata_a_d = get_word(pmem_rdata, xfer_q.widx);
                    state_d   = RESP_A;
                end
            end
            RD_B: begin
                if (pmem_resp) begin
                    rdata_b_d = get_word(pmem_rdata, xfer_q.widx);
                    state_d   = RESP_B;
                end
            end
            WR_FETCH: begin
                if (pmem_resp) begin
                    pmem_wdata_d = merged_c;
                    state_d      = WR_STORE;
                end
            end
            WR_STORE: begin
                if (pmem_resp) begin
                    state_d = RESP_B;
                end
            end
            RESP_A: state_d = IDLE;
            RESP_B: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs follow the state being entered so they come straight off flops.
        pmem_read_d  = (state_d == RD_A) || (state_d == RD_B) || (state_d == WR_FETCH);
        pmem_write_d = (state_d == WR_STORE);
        resp_a_d     = (state_d == RESP_A);
        resp_b_d     = (state_d == RESP_B);
    end

    // State, arbitration flag, capture and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_b_q     <= 1'b0;
            xfer_q       <= '0;
            resp_a       <= 1'b0;
            resp_b       <= 1'b0;
            rdata_a      <= '0;
            rdata_b      <= '0;
            pmem_read    <= 1'b0;
            pmem_write   <= 1'b0;
            pmem_address <= '0;
            pmem_wdata   <= '0;
        end else begin
            state_q      <= state_d;
            last_b_q     <= last_b_d;
            xfer_q       <= xfer_d;
            resp_a       <= resp_a_d;
            resp_b       <= resp_b_d;
            rdata_a      <= rdata_a_d;
            rdata_b      <= rdata_b_d;
            pmem_read    <= pmem_read_d;
            pmem_write   <= pmem_write_d;
            pmem_address <= pmem_address_d;
            pmem_wdata   <= pmem_wdata_d;
        end
    end

`ifndef SYNTHESIS
    // A simultaneous read_b/write is served as a write but flagged.
    always @(posedge clk) begin
        if (rst_n && (state_q == IDLE)) begin
            assert (!(read_b && write))
                else $error("mem_line_arbiter: read_b and write asserted together");
        end
    end
`endif

endmodule

// File: tb/tb_mem_line_arbiter.sv
// Directed and randomised checks of mem_line_arbiter against a line memory model.
module tb_mem_line_arbiter;

    logic         clk;
    logic         rst_n;
    logic         read_a;
    logic [31:0]  address_a;
    logic         resp_a;
    logic [31:0]  rdata_a;
    logic         read_b;
    logic         write;
    logic [31:0]  address_b;
    logic [31:0]  wdata;
    logic [3:0]   mbe;
    logic         resp_b;
    logic [31:0]  rdata_b;
    logic         pmem_read;
    logic         pmem_write;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_wdata;
    logic [255:0] pmem_rdata;
    logic         pmem_resp;

    int checks;
    int errors;

    mem_line_arbiter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .read_a       (read_a),
        .address_a    (address_a),
        .resp_a       (resp_a),
        .rdata_a      (rdata_a),
        .read_b       (read_b),
        .write        (write),
        .address_b    (address_b),
        .wdata        (wdata),
        .mbe          (mbe),
        .resp_b       (resp_b),
        .rdata_b      (rdata_b),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Initial line contents, shared by the memory model and the expected copy.
    function automatic logic [255:0] pat_line(input int l);
        logic [255:0] v;
        for (int w = 0; w < 8; w++) begin
            v[w*32 +: 32] = {8'(l), 8'(w), 8'hA5, 8'(l*16 + w)};
        end
        if (l == 2) v[1*32 +: 32] = 32'hDEADBEEF;
        if (l == 8) v[2*32 +: 32] = 32'h11223344;
        return v;
    endfunction

    function automatic logic [31:0] tb_word(input logic [255:0] line, input logic [31:0] addr);
        int base;
        base = int'(addr[4:2]) * 32;
        return line[base +: 32];
    endfunction

    function automatic logic [255:0] tb_merge(input logic [255:0] line, input logic [31:0] addr,
                                              input logic [31:0] d, input logic [3:0] m);
        int base;
        base = int'(addr[4:2]) * 32;
        for (int i = 0; i < 4; i++) begin
            if (m[i]) line[base + 8*i +: 8] = d[8*i +: 8];
        end
        return line;
    endfunction

    // Physical memory model: pmem_resp arrives lat cycles after the request is seen in IDLE.
    logic [255:0] pmem_mem [16];
    logic         loaded = 1'b0;
    int           lat;
    int           cnt;
    logic         fire;

    assign fire = (pmem_read || pmem_write) && !pmem_resp && (cnt >= lat - 2);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pmem_resp <= 1'b0;
            cnt       <= 0;
        end else if (pmem_resp) begin
            pmem_resp <= 1'b0;
        end else if (fire) begin
            pmem_resp <= 1'b1;
            cnt       <= 0;
        end else if (pmem_read || pmem_write) begin
            cnt <= cnt + 1;
        end
    end

    always @(posedge clk) begin
        if (!loaded) begin
            for (int l = 0; l < 16; l++) pmem_mem[l] <= pat_line(l);
            loaded <= 1'b1;
        end else if (fire && rst_n) begin
            if (pmem_write) pmem_mem[pmem_address[8:5]] <= pmem_wdata;
            pmem_rdata <= pmem_mem[pmem_address[8:5]];
        end
    end

    // Line read and line write are mutually exclusive at all times.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            checks++;
            assert (!(pmem_read === 1'b1 && pmem_write === 1'b1)) else begin
                errors++;
                $error("FAIL pmem_excl: observed read=%0b write=%0b expected not both", pmem_read, pmem_write);
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [255:0] shadow [16];
    logic [255:0] cap_wdata;
    logic         saw_rd, saw_wr;
    int           cyc;
    logic         got_a, got_b;

    // Count negedges until a response pulse, noting pmem activity on the way.
    task automatic wait_resp();
        cyc    = 0;
        saw_rd = 1'b0;
        saw_wr = 1'b0;
        do begin
            @(negedge clk);
            cyc++;
            if (pmem_read)  saw_rd = 1'b1;
            if (pmem_write) begin
                saw_wr    = 1'b1;
                cap_wdata = pmem_wdata;
            end
        end while (!resp_a && !resp_b && cyc < 200);
        got_a = resp_a;
        got_b = resp_b;
        chk("resp_seen", 256'(resp_a | resp_b), 256'(1));
    endtask

    task automatic read_txn(input bit port_b, input logic [31:0] addr, input logic [31:0] exp,
                            input int exp_cyc, input string tag);
        if (port_b) begin
            read_b    = 1'b1;
            address_b = addr;
        end else begin
            read_a    = 1'b1;
            address_a = addr;
        end
        wait_resp();
        chk({tag, "_port"}, 256'({got_a, got_b}), port_b ? 256'(2'b01) : 256'(2'b10));
        chk({tag, "_data"}, 256'(port_b ? rdata_b : rdata_a), 256'(exp));
        chk({tag, "_lat"},  256'(cyc), 256'(exp_cyc));
        read_a = 1'b0;
        read_b = 1'b0;
        @(negedge clk);
        chk({tag, "_pulse"}, 256'({resp_a, resp_b}), 256'(0));
    endtask

    task automatic write_txn(input logic [31:0] addr, input logic [31:0] d, input logic [3:0] m,
                             input string tag);
        logic [255:0] exp_line;
        int           exp_cyc;
        exp_line  = tb_merge(shadow[addr[8:5]], addr, d, m);
        exp_cyc   = (m == 4'b0000) ? 1 : 2*lat + 1;
        write     = 1'b1;
        address_b = addr;
        wdata     = d;
        mbe       = m;
        wait_resp();
        chk({tag, "_port"},  256'({got_a, got_b}), 256'(2'b01));
        chk({tag, "_rdata"}, 256'(rdata_b), 256'(0));
        chk({tag, "_lat"},   256'(cyc), 256'(exp_cyc));
        if (m != 4'b0000) begin
            chk({tag, "_line"}, cap_wdata, exp_line);
        end else begin
            chk({tag, "_nopmem"}, 256'({saw_rd, saw_wr}), 256'(0));
        end
        shadow[addr[8:5]] = exp_line;
        write = 1'b0;
        mbe   = 4'b0000;
        @(negedge clk);
        chk({tag, "_pulse"}, 256'({resp_a, resp_b}), 256'(0));
    endtask

    task automatic chk_outs_zero(input string tag);
        chk({tag, "_ctl"}, 256'({resp_a, resp_b, pmem_read, pmem_write, rdata_a, rdata_b, pmem_address}), 256'(0));
        chk({tag, "_wdata"}, pmem_wdata, 256'(0));
    endtask

    initial begin
        logic [31:0] addr;
        logic [31:0] d;
        logic [3:0]  m;
        int          op;

        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        read_a    = 1'b0;
        read_b    = 1'b0;
        write     = 1'b0;
        address_a = '0;
        address_b = '0;
        wdata     = '0;
        mbe       = '0;
        lat       = 3;
        for (int l = 0; l < 16; l++) shadow[l] = pat_line(l);

        repeat (3) @(negedge clk);
        chk_outs_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);
        chk_outs_zero("post_reset");

        // Fetch read: 0x44 is line 2, word 1.
        read_txn(1'b0, 32'h0000_0044, 32'hDEADBEEF, 4, "rd_a_44");

        // Store with bytes 0 and 2 enabled into word 2 of line 8.
        write_txn(32'h0000_0108, 32'hAABBCCDD, 4'b0101, "wr_108");
        chk("wr_108_word2", 256'(cap_wdata[95:64]), 256'(32'h11BB33DD));
        read_txn(1'b1, 32'h0000_0108, 32'h11BB33DD, 4, "rd_b_108");
        read_txn(1'b0, 32'h0000_010C, tb_word(pat_line(8), 32'h10C), 4, "rd_a_10c");

        // Empty byte mask completes without touching memory.
        write_txn(32'h0000_01F4, 32'hFFFF_FFFF, 4'b0000, "wr_mbe0");

        // Conflicts right after reset: B, then A, then B again.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        lat       = 2;
        read_a    = 1'b1;
        address_a = 32'h0000_0070;
        read_b    = 1'b1;
        address_b = 32'h0000_00DC;
        wait_resp();
        chk("arb1_port", 256'({got_a, got_b}), 256'(2'b01));
        chk("arb1_data", 256'(rdata_b), 256'(tb_word(shadow[6], 32'hDC)));
        chk("arb1_lat",  256'(cyc), 256'(3));
        wait_resp();
        chk("arb2_port", 256'({got_a, got_b}), 256'(2'b10));
        chk("arb2_data", 256'(rdata_a), 256'(tb_word(shadow[3], 32'h70)));
        chk("arb2_lat",  256'(cyc), 256'(4));
        read_a = 1'b0;
        wait_resp();
        chk("arb3_port", 256'({got_a, got_b}), 256'(2'b01));
        chk("arb3_data", 256'(rdata_b), 256'(tb_word(shadow[6], 32'hDC)));
        chk("arb3_lat",  256'(cyc), 256'(4));
        read_b = 1'b0;
        @(negedge clk);

        // Reset while the merged line is being written back.
        lat       = 3;
        write     = 1'b1;
        address_b = 32'h0000_00A0;
        wdata     = 32'hFFFF_FFFF;
        mbe       = 4'b1111;
        cyc       = 0;
        while (!pmem_write && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("rst_store_reached", 256'(pmem_write), 256'(1));
        chk("rst_store_lat",     256'(cyc), 256'(4));
        #1;
        rst_n = 1'b0;
        write = 1'b0;
        mbe   = 4'b0000;
        #1;
        chk_outs_zero("rst_store");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        read_txn(1'b0, 32'h0000_00A0, tb_word(shadow[5], 32'hA0), 4, "rd_after_rst");

        // Mixed single-port traffic with varying memory latency.
        for (int i = 0; i < 300; i++) begin
            lat  = int'($urandom_range(2, 5));
            op   = int'($urandom_range(0, 2));
            addr = 32'($urandom_range(0, 511));
            case (op)
                0: read_txn(1'b0, addr, tb_word(shadow[addr[8:5]], addr), lat + 1, "rnd_rd_a");
                1: read_txn(1'b1, addr, tb_word(shadow[addr[8:5]], addr), lat + 1, "rnd_rd_b");
                default: begin
                    d = $urandom;
                    m = 4'($urandom_range(0, 15));
                    write_txn(addr, d, m, "rnd_wr");
                end
            endcase
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
